// File: rtl/aes_pkg.sv
// Shared AES helpers for the key expander: mode encoding, Nk/Nr lookup,
// xtime, Rcon seed and the forward S-box.
package aes_pkg;

  typedef enum logic [1:0] {
    AES128 = 2'b00,
    AES192 = 2'b01,
    AES256 = 2'b10
  } aes_mode_e;

  localparam logic [7:0] RCON_INIT = 8'h01;

  // Row-major S-box, entry 0x00 in the top byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic aes_mode_e mode_decode(input logic [1:0] m);
    case (m)
      2'b00:   return AES128;
      2'b01:   return AES192;
      default: return AES256;
    endcase
  endfunction

  function automatic logic [3:0] nk_of(input aes_mode_e m);
    case (m)
      AES128:  return 4'd4;
      AES192:  return 4'd6;
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input aes_mode_e m);
    return nk_of(m) + 4'd6;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[{~b, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/sub_word.sv
// SubWord: four parallel S-box lookups on a 32-bit word.
module sub_word
  import aes_pkg::*;
(
  input  logic [31:0] data_i,
  output logic [31:0] data_o
);

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    assign data_o[8*b +: 8] = sbox(data_i[8*b +: 8]);
  end

endmodule

// File: rtl/key_exp_seq.sv
// Sequential AES-128/192/256 key expander, one schedule word per cycle, with
// a registered round-key read port. Optional zeroize input: KEY_EXP_ZEROIZE_EN.
//   state  | meaning
//   IDLE   | no schedule requested since reset/zeroize
//   LOAD   | copy cipher key into w[0..Nk-1]
//   EXPAND | derive w[Nk..Wtot-1], one word per cycle
//   DONE   | schedule complete, readable; start re-arms
module key_exp_seq
  import aes_pkg::*;
#(
  parameter int NK_MAX = 8,
  parameter int NB     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef KEY_EXP_ZEROIZE_EN
  input  logic                  zeroize,
`endif
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [32*NK_MAX-1:0]  key,
  output logic                  busy,
  output logic                  done,
  output logic                  rk_valid,
  input  logic [3:0]            rk_idx,
  output logic [32*NB-1:0]      rk_out,
  output logic [3:0]            nr_out
);

  localparam int NR_MAX = NK_MAX + 6;
  localparam int W_MAX  = NB * (NR_MAX + 1);
  localparam int IW     = $clog2(W_MAX);

  typedef enum logic [1:0] {IDLE, LOAD, EXPAND, DONE} state_e;

  state_e            state_q, state_d;
  aes_mode_e         mode_q;
  logic [3:0]        nr_q, nk;
  logic [IW-1:0]     i_q, wtot, rd_base;
  logic [2:0]        ph_q;
  logic [7:0]        rcon_q;
  logic [31:0]       store_q [W_MAX];
  logic              busy_q, done_q, rk_valid_q;
  logic [32*NB-1:0]  rk_out_q, rk_rd;
  logic              accept, load_en, exp_en, last, zero_en;
  logic              rot_en, sub_en, ph_last;
  logic [31:0]       temp, sw_in, sw_out, w_new;

`ifdef KEY_EXP_ZEROIZE_EN
  assign zero_en = zeroize;
`else
  assign zero_en = 1'b0;
`endif

  assign nk      = nk_of(mode_q);
  assign wtot    = IW'(NB * (int'(nr_q) + 1));
  assign ph_last = ({1'b0, ph_q} == nk - 4'd1);
  assign rot_en  = (ph_q == 3'd0);
  assign sub_en  = (nk == 4'd8) && (ph_q == 3'd4);

  assign temp  = store_q[i_q - IW'(1)];
  assign sw_in = rot_en ? {temp[23:0], temp[31:24]} : temp;
  assign w_new = store_q[i_q - IW'(nk)] ^
                 (rot_en ? (sw_out ^ {rcon_q, 24'h0}) : (sub_en ? sw_out : temp));

  sub_word u_sub_word (
    .data_i (sw_in),
    .data_o (sw_out)
  );

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    load_en = 1'b0;
    exp_en  = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE, DONE: if (start) begin
        accept  = 1'b1;
        state_d = LOAD;
      end
      LOAD: begin
        load_en = 1'b1;
        state_d = EXPAND;
      end
      EXPAND: begin
        exp_en = 1'b1;
        if (i_q == wtot - IW'(1)) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Zeroize wins over everything, including a same-cycle start.
    if (zero_en) begin
      state_d = IDLE;
      accept  = 1'b0;
      load_en = 1'b0;
      exp_en  = 1'b0;
      last    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  assign rd_base = IW'(NB * int'(rk_idx));

  always_comb begin
    rk_rd = '0;
    if (rk_valid_q && (rk_idx <= nr_q)) begin
      for (int j = 0; j < NB; j++) begin
        rk_rd[32*(NB-1-j) +: 32] = store_q[rd_base + IW'(j)];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= AES128;
      nr_q       <= 4'd0;
      i_q        <= '0;
      ph_q       <= 3'd0;
      rcon_q     <= RCON_INIT;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rk_valid_q <= 1'b0;
      rk_out_q   <= '0;
      for (int j = 0; j < W_MAX; j++) store_q[j] <= 32'h0;
    end else if (zero_en) begin
      i_q        <= '0;
      ph_q       <= 3'd0;
      rcon_q     <= 8'h00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rk_valid_q <= 1'b0;
      rk_out_q   <= '0;
      for (int j = 0; j < W_MAX; j++) store_q[j] <= 32'h0;
    end else begin
      done_q   <= last;
      rk_out_q <= rk_rd;
      if (accept) begin
        mode_q     <= mode_decode(mode);
        nr_q       <= nr_of(mode_decode(mode));
        busy_q     <= 1'b1;
        rk_valid_q <= 1'b0;
      end
      if (load_en) begin
        for (int j = 0; j < NK_MAX; j++) begin
          if (j < int'(nk)) store_q[j] <= key[32*NK_MAX-1-32*j -: 32];
        end
        i_q    <= IW'(nk);
        ph_q   <= 3'd0;
        rcon_q <= RCON_INIT;
      end
      if (exp_en) begin
        store_q[i_q] <= w_new;
        i_q          <= i_q + IW'(1);
        ph_q         <= ph_last ? 3'd0 : ph_q + 3'd1;
        if (rot_en) rcon_q <= xtime(rcon_q);
      end
      if (last) begin
        busy_q     <= 1'b0;
        rk_valid_q <= 1'b1;
      end
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rk_valid = rk_valid_q;
  assign rk_out   = rk_out_q;
  assign nr_out   = nr_q;

endmodule

// File: tb/tb_key_exp_seq.sv
// Directed bench for key_exp_seq using FIPS-197 key schedules.
module tb_key_exp_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         zeroize;
  logic         start;
  logic [1:0]   mode;
  logic [255:0] key;
  logic         busy, done, rk_valid;
  logic [3:0]   rk_idx;
  logic [127:0] rk_out;
  logic [3:0]   nr_out;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  always #5 clk = ~clk;

  key_exp_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef KEY_EXP_ZEROIZE_EN
    .zeroize  (zeroize),
`endif
    .start    (start),
    .mode     (mode),
    .key      (key),
    .busy     (busy),
    .done     (done),
    .rk_valid (rk_valid),
    .rk_idx   (rk_idx),
    .rk_out   (rk_out),
    .nr_out   (nr_out)
  );

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic read_rk(input logic [3:0] idx, output logic [127:0] val);
    @(negedge clk);
    rk_idx = idx;
    @(posedge clk);
    #1 val = rk_out;
  endtask

  task automatic run(input logic [1:0] m, input logic [255:0] k, input bit disturb,
                     output int lat, output int ndone);
    lat   = -1;
    ndone = 0;
    @(negedge clk);
    mode  = m;
    key   = k;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 70; c++) begin
      if (disturb) begin
        start = (c >= 5 && c <= 30 && (c % 3) == 0);
        mode  = (c >= 5 && c <= 30) ? ~m : m;
        key   = (c >= 5 && c <= 30) ? ~k : k;
      end
      @(posedge clk);
      #1;
      if (c == 10) begin
        check("busy_mid", busy, 1'b1);
        check("rk_out_busy", rk_out, 128'h0);
      end
      if (done) begin
        ndone++;
        if (lat < 0) lat = c;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] rk;
    int lat, nd;
    rst_n = 1'b0; zeroize = 1'b0; start = 1'b0; mode = 2'b00; key = '0; rk_idx = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_rk_valid", rk_valid, 1'b0);
    check("rst_rk_out", rk_out, 128'h0);
    check("rst_nr_out", nr_out, 4'd0);
    @(negedge clk) rst_n = 1'b1;

    // AES-128
    run(2'b00, K128, 1'b0, lat, nd);
    check("aes128_latency", lat, 41);
    check("aes128_done_cnt", nd, 1);
    check("aes128_nr", nr_out, 4'd10);
    check("aes128_valid", rk_valid, 1'b1);
    check("aes128_busy_end", busy, 1'b0);
    read_rk(4'd10, rk); check("aes128_rk10", rk, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    read_rk(4'd0,  rk); check("aes128_rk0",  rk, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    read_rk(4'd1,  rk); check("aes128_rk1",  rk, 128'ha0fafe1788542cb123a339392a6c7605);
    read_rk(4'd11, rk); check("aes128_rk11", rk, 128'h0);
    read_rk(4'd15, rk); check("aes128_rk15", rk, 128'h0);

    // AES-192
    run(2'b01, K192, 1'b0, lat, nd);
    check("aes192_latency", lat, 47);
    check("aes192_done_cnt", nd, 1);
    check("aes192_nr", nr_out, 4'd12);
    read_rk(4'd12, rk); check("aes192_rk12", rk, 128'he98ba06f448c773c8ecc720401002202);
    read_rk(4'd1,  rk); check("aes192_rk1",  rk, 128'h62f8ead2522c6b7bfe0c91f72402f5a5);
    read_rk(4'd13, rk); check("aes192_rk13", rk, 128'h0);

    // AES-256
    run(2'b10, K256, 1'b0, lat, nd);
    check("aes256_latency", lat, 53);
    check("aes256_done_cnt", nd, 1);
    check("aes256_nr", nr_out, 4'd14);
    read_rk(4'd14, rk); check("aes256_rk14", rk, 128'hfe4890d1e6188d0b046df344706c631e);
    read_rk(4'd0,  rk); check("aes256_rk0",  rk, 128'h603deb1015ca71be2b73aef0857d7781);
    read_rk(4'd2,  rk); check("aes256_rk2",  rk, 128'h9ba354118e6925afa51a8b5f2067fcde);
    read_rk(4'd3,  rk); check("aes256_rk3",  rk, 128'ha8b09c1a93d194cdbe49846eb75d5b9a);

    // AES-128 with start/mode/key disturbed while busy
    run(2'b00, K128, 1'b1, lat, nd);
    check("dist_latency", lat, 41);
    check("dist_done_cnt", nd, 1);
    check("dist_nr", nr_out, 4'd10);
    read_rk(4'd10, rk); check("dist_rk10", rk, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    read_rk(4'd11, rk); check("dist_rk11", rk, 128'h0);

    // Reset in the middle of an AES-256 run (mode 11 aliases AES-256)
    nd = 0;
    @(negedge clk);
    mode = 2'b11; key = K256; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1 if (done) nd++;
    end
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_valid", rk_valid, 1'b0);
    check("midrst_nr", nr_out, 4'd0);
    check("midrst_rk_out", rk_out, 128'h0);
    check("midrst_no_done", nd, 0);
    @(negedge clk) rst_n = 1'b1;
    run(2'b00, K128, 1'b0, lat, nd);
    check("after_rst_latency", lat, 41);
    check("after_rst_done_cnt", nd, 1);
    read_rk(4'd10, rk); check("after_rst_rk10", rk, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    read_rk(4'd1,  rk); check("after_rst_rk1",  rk, 128'ha0fafe1788542cb123a339392a6c7605);

    // Mode 11 behaves as AES-256
    run(2'b11, K256, 1'b0, lat, nd);
    check("mode11_latency", lat, 53);
    check("mode11_nr", nr_out, 4'd14);
    read_rk(4'd14, rk); check("mode11_rk14", rk, 128'hfe4890d1e6188d0b046df344706c631e);

`ifdef KEY_EXP_ZEROIZE_EN
    @(negedge clk);
    zeroize = 1'b1; start = 1'b1; mode = 2'b00; key = K128;
    @(posedge clk);
    #1 zeroize = 1'b0; start = 1'b0;
    check("zero_valid", rk_valid, 1'b0);
    check("zero_busy", busy, 1'b0);
    check("zero_rk_out", rk_out, 128'h0);
    for (int r = 0; r < 15; r++) begin
      read_rk(4'(r), rk);
      check("zero_rk_read", rk, 128'h0);
    end
    check("zero_no_start", busy, 1'b0);
    check("zero_no_done", done, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
